// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state and grant types for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} arb_gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - I/D requester and RAM-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_valid;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_valid;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wd;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic                  stall_if;
    logic                  stall_mem;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rd,
        input  i_rdata, i_valid, d_rdata, d_valid,
        input  ram_addr, ram_wd, ram_we, ram_re, stall_if, stall_mem
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rd,
        output i_rdata, i_valid, d_rdata, d_valid,
        output ram_addr, ram_wd, ram_we, ram_re, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - combinational I/D grant selection
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  logic     d_we,
    input  arb_gnt_t last_grant,
    output arb_gnt_t grant
);

    // Evictions jump the queue so the cache line is freed before any refill.
    always_comb begin
        grant = GNT_I;
        if (d_req && d_we) begin
            grant = GNT_D;
        end else if (d_req && i_req) begin
            grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between I and D requesters via a fixed-latency FSM
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int RAM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    arb_gnt_t              gnt_q, gnt_d;
    arb_gnt_t              last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wd_q, ram_wd_d;
    logic                  ram_we_q, ram_we_d;
    logic                  ram_re_q, ram_re_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    arb_gnt_t              sel_gnt;
    logic                  i_valid;
    logic                  d_valid;

    mem_arb_select u_select (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .d_we       (bus.d_we),
        .last_grant (last_q),
        .grant      (sel_gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        we_d       = we_q;
        ram_addr_d = ram_addr_q;
        ram_wd_d   = ram_wd_q;
        ram_we_d   = 1'b0;
        ram_re_d   = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    gnt_d      = sel_gnt;
                    last_d     = sel_gnt;
                    we_d       = (sel_gnt == GNT_D) && bus.d_we;
                    ram_addr_d = (sel_gnt == GNT_D) ? bus.d_addr : bus.i_addr;
                    if ((sel_gnt == GNT_D) && bus.d_we) begin
                        ram_wd_d = bus.d_wdata;
                    end
                    // Strobes are registered, so they are raised on entry to ISSUE.
                    ram_we_d   = (sel_gnt == GNT_D) && bus.d_we;
                    ram_re_d   = !((sel_gnt == GNT_D) && bus.d_we);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(RAM_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_q == GNT_D) begin
                        d_rdata_d = bus.ram_rd;
                    end else begin
                        i_rdata_d = bus.ram_rd;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= GNT_I;
            last_q     <= GNT_I;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_wd_q   <= '0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            ram_addr_q <= ram_addr_d;
            ram_wd_q   <= ram_wd_d;
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_valid       = (state_q == RESP) && (gnt_q == GNT_I);
    assign d_valid       = (state_q == RESP) && (gnt_q == GNT_D);
    assign bus.i_valid   = i_valid;
    assign bus.d_valid   = d_valid;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wd    = ram_wd_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.stall_if  = bus.i_req & ~i_valid;
    assign bus.stall_mem = bus.d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at RAM_LATENCY 1 and 2
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit lane_done [2];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        off = 32'($urandom_range(0, 7)) * 32'd4;
        case ($urandom_range(0, 3))
            0:       return 32'h100;
            1:       return 32'h200;
            2:       return 32'h300;
            default: return 32'h400 + off;
        endcase
    endfunction

    function automatic void chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lane%0d %s: got 0x%08h expected 0x%08h", ln, nm, act, exp);
        end
    endfunction

    function automatic void chkb(input string nm, input int ln, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lane%0d %s: got %b expected %b", ln, nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = g + 1;
        localparam int P   = 3 + LAT;

        logic rst = 1'b1;
        mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

        mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_LATENCY(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // RAM stub: data appears LAT cycles after the ram_re cycle, junk otherwise
        logic [31:0] ram [0:1023];
        logic [31:0] rd_pipe [0:LAT-1];
        logic        vld_pipe [0:LAT-1];
        logic [31:0] junk;

        initial begin
            for (int i = 0; i < 1024; i++) ram[i] = dflt(32'(i) * 32'd4);
            ram[32'h100 >> 2] = 32'hDEADBEEF;
            forever begin
                @(posedge clk);
                if (bus.ram_we === 1'b1) ram[bus.ram_addr[11:2]] = bus.ram_wd;
                rd_pipe[0]  <= ram[bus.ram_addr[11:2]];
                vld_pipe[0] <= bus.ram_re;
                for (int i = 1; i < LAT; i++) begin
                    rd_pipe[i]  <= rd_pipe[i-1];
                    vld_pipe[i] <= vld_pipe[i-1];
                end
                junk <= $urandom;
            end
        end

        assign bus.ram_rd = (vld_pipe[LAT-1] === 1'b1) ? rd_pipe[LAT-1] : junk;

        // Transaction-level model: one access at a time, outputs at fixed offsets from the sample cycle
        initial begin
            int          cyc, iss, val;
            bit          busy, was_rst, m_d, m_we, last_d;
            bit          e_iv, e_dv, e_re, e_we;
            logic [31:0] m_addr, m_wd, m_rd;
            logic [31:0] mmem [0:1023];
            cyc = 0; iss = 0; val = 0;
            busy = 0; was_rst = 0; m_d = 0; m_we = 0; last_d = 0;
            m_addr = '0; m_wd = '0; m_rd = '0;
            for (int i = 0; i < 1024; i++) mmem[i] = dflt(32'(i) * 32'd4);
            mmem[32'h100 >> 2] = 32'hDEADBEEF;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    was_rst = 1;
                    continue;
                end
                if (was_rst) begin
                    chkb("rst_i_valid", g, bus.i_valid, 1'b0);
                    chkb("rst_d_valid", g, bus.d_valid, 1'b0);
                    chkb("rst_ram_we", g, bus.ram_we, 1'b0);
                    chkb("rst_ram_re", g, bus.ram_re, 1'b0);
                    chk("rst_ram_addr", g, bus.ram_addr, 32'h0);
                    chk("rst_ram_wd", g, bus.ram_wd, 32'h0);
                    chk("rst_i_rdata", g, bus.i_rdata, 32'h0);
                    chk("rst_d_rdata", g, bus.d_rdata, 32'h0);
                    busy = 0; last_d = 0; was_rst = 0;
                end
                if (busy && cyc > val) busy = 0;
                if (!busy && (bus.i_req || bus.d_req)) begin
                    if (bus.d_req && bus.d_we)      m_d = 1;
                    else if (bus.d_req && bus.i_req) m_d = !last_d;
                    else                             m_d = bus.d_req;
                    last_d = m_d;
                    m_we   = m_d && bus.d_we;
                    m_addr = m_d ? bus.d_addr : bus.i_addr;
                    m_wd   = bus.d_wdata;
                    busy   = 1;
                    iss    = cyc + 1;
                    val    = cyc + (m_we ? 2 : 2 + LAT);
                    if (m_we) mmem[m_addr[11:2]] = m_wd;
                    else      m_rd = mmem[m_addr[11:2]];
                end
                e_iv = busy && cyc == val && !m_d;
                e_dv = busy && cyc == val && m_d;
                e_re = busy && cyc == iss && !m_we;
                e_we = busy && cyc == iss && m_we;
                chkb("m_ram_re", g, bus.ram_re, e_re);
                chkb("m_ram_we", g, bus.ram_we, e_we);
                chkb("m_i_valid", g, bus.i_valid, e_iv);
                chkb("m_d_valid", g, bus.d_valid, e_dv);
                chkb("m_stall_if", g, bus.stall_if, bus.i_req & ~e_iv);
                chkb("m_stall_mem", g, bus.stall_mem, bus.d_req & ~e_dv);
                chkb("m_we_re_excl", g, bus.ram_we & bus.ram_re, 1'b0);
                chkb("m_valid_excl", g, bus.i_valid & bus.d_valid, 1'b0);
                if (e_re || e_we) chk("m_ram_addr", g, bus.ram_addr, m_addr);
                if (e_we)         chk("m_ram_wd", g, bus.ram_wd, m_wd);
                if (e_iv)         chk("m_i_rdata", g, bus.i_rdata, m_rd);
                if (e_dv && !m_we) chk("m_d_rdata", g, bus.d_rdata, m_rd);
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        initial begin
            bit ivs, dvs;
            bus.i_req = 0; bus.i_addr = '0;
            bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
            repeat (3) step();
            rst = 0;
            repeat (3) step();

            // I read of 0x100
            bus.i_req = 1; bus.i_addr = 32'h100;
            #1;
            chkb("t1_stall_c0", g, bus.stall_if, 1'b1);
            for (int k = 1; k <= 2 + LAT; k++) begin
                step();
                chkb("t1_ram_re", g, bus.ram_re, k == 1);
                chkb("t1_i_valid", g, bus.i_valid, k == 2 + LAT);
                chkb("t1_stall_if", g, bus.stall_if, k < 2 + LAT);
            end
            chk("t1_i_rdata", g, bus.i_rdata, 32'hDEADBEEF);
            bus.i_req = 0;
            step();

            // D write 0x200 then D read back
            bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
            for (int k = 1; k <= 2; k++) begin
                step();
                chkb("t2_ram_we", g, bus.ram_we, k == 1);
                chkb("t2_d_valid", g, bus.d_valid, k == 2);
                if (k == 1) begin
                    chk("t2_ram_addr", g, bus.ram_addr, 32'h200);
                    chk("t2_ram_wd", g, bus.ram_wd, 32'h12345678);
                end
            end
            bus.d_req = 0;
            step();
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
            for (int k = 1; k <= 2 + LAT; k++) begin
                step();
                chkb("t2r_ram_re", g, bus.ram_re, k == 1);
                chkb("t2r_d_valid", g, bus.d_valid, k == 2 + LAT);
            end
            chk("t2r_d_rdata", g, bus.d_rdata, 32'h12345678);
            bus.d_req = 0;
            step();

            // Held tie after reset: D, I, D, I every P cycles
            rst = 1;
            step();
            rst = 0;
            bus.i_req = 1; bus.i_addr = 32'h300;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
            for (int k = 1; k <= 4 * P - 1; k++) begin
                bit hit, side_d;
                step();
                hit    = (k >= 2 + LAT) && ((k - (2 + LAT)) % P == 0);
                side_d = (((k - (2 + LAT)) / P) % 2) == 0;
                chkb("t3_i_valid", g, bus.i_valid, hit && !side_d);
                chkb("t3_d_valid", g, bus.d_valid, hit && side_d);
                if (hit && side_d)  chk("t3_d_rdata", g, bus.d_rdata, 32'hDEADBEEF);
                if (hit && !side_d) chk("t3_i_rdata", g, bus.i_rdata, dflt(32'h300));
            end
            bus.i_req = 0; bus.d_req = 0;
            step();

            // last_grant=D, then I read and D write together: write still first
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
            repeat (2 + LAT) step();
            chkb("t4_pre_d_valid", g, bus.d_valid, 1'b1);
            bus.d_req = 0;
            step();
            bus.i_req = 1; bus.i_addr = 32'h300;
            bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'hCAFEF00D;
            for (int k = 1; k <= 5 + LAT; k++) begin
                step();
                chkb("t4_d_valid", g, bus.d_valid, k == 2);
                chkb("t4_i_valid", g, bus.i_valid, k == 5 + LAT);
                if (k == 2) bus.d_req = 0;
            end
            chk("t4_i_rdata", g, bus.i_rdata, 32'hCAFEF00D);
            bus.i_req = 0;
            step();

            // Reset during WAIT of an I read
            bus.i_req = 1; bus.i_addr = 32'h100;
            step();
            step();
            rst = 1;
            step();
            rst = 0;
            chkb("t5_i_valid", g, bus.i_valid, 1'b0);
            chkb("t5_ram_re", g, bus.ram_re, 1'b0);
            chk("t5_ram_addr", g, bus.ram_addr, 32'h0);
            chk("t5_i_rdata", g, bus.i_rdata, 32'h0);
            for (int k = 4; k <= 5 + LAT; k++) begin
                step();
                chkb("t5_ram_re_re", g, bus.ram_re, k == 4);
                chkb("t5_i_valid_re", g, bus.i_valid, k == 5 + LAT);
            end
            chk("t5_i_rdata_re", g, bus.i_rdata, 32'hDEADBEEF);
            bus.i_req = 0;
            step();

            // Random traffic with occasional resets
            for (int n = 0; n < 3000; n++) begin
                ivs = bus.i_valid;
                dvs = bus.d_valid;
                step();
                rst = ($urandom_range(0, 299) == 0);
                if (!bus.i_req || ivs) begin
                    bus.i_req  = ($urandom_range(0, 2) != 0);
                    bus.i_addr = rand_addr();
                end
                if (!bus.d_req || dvs) begin
                    bus.d_req   = ($urandom_range(0, 2) != 0);
                    bus.d_we    = $urandom_range(0, 1) == 1;
                    bus.d_addr  = rand_addr();
                    bus.d_wdata = $urandom;
                end
            end
            rst = 0; bus.i_req = 0; bus.d_req = 0;
            repeat (12) step();
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (lane_done[0] && lane_done[1]) break;
        end
        checks++;
        if (!(lane_done[0] && lane_done[1])) begin
            failures++;
            $display("FAIL timeout: lanes done %b%b expected 11", lane_done[1], lane_done[0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
